// File: rtl/fft_iter_if.sv
// Streaming handshake bundle for the iterative FFT: sample input, inverse select,
// and result output with end-of-frame marker.
interface fft_iter_if #(
   parameter int DATA_WIDTH = 16
);
   logic                      fft_ready_in;
   logic                      fft_valid_in;
   logic [2*DATA_WIDTH-1:0]   fft_data_in;
   logic                      fft_inverse;
   logic                      fft_ready_out;
   logic                      fft_valid_out;
   logic [2*DATA_WIDTH-1:0]   fft_data_out;
   logic                      fft_last_out;

   modport master (
      input  fft_ready_in,
      output fft_valid_in,
      output fft_data_in,
      output fft_inverse,
      output fft_ready_out,
      input  fft_valid_out,
      input  fft_data_out,
      input  fft_last_out
   );

   modport slave (
      output fft_ready_in,
      input  fft_valid_in,
      input  fft_data_in,
      input  fft_inverse,
      input  fft_ready_out,
      output fft_valid_out,
      output fft_data_out,
      output fft_last_out
   );
endinterface

// File: rtl/fft_iter.sv
// In-place iterative radix-2 DIT FFT: one butterfly per cycle over an N-entry
// complex register array, frame-at-a-time load / compute / unload.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_LOAD    | accepting samples, written at bit-reversed addresses
// ST_COMPUTE | one butterfly per cycle, log2(N) stages of N/2 butterflies
// ST_UNLOAD  | streaming bins 0..N-1 in natural order through output register
module fft_iter #(
   parameter int DATA_WIDTH = 16,
   parameter int FRACTION   = 11,
   parameter int FFT_POINTS = 8
) (
   input logic       clk,
   input logic       rst,
   fft_iter_if.slave bus
);
   localparam int  DW = DATA_WIDTH;
   localparam int  AW = $clog2(FFT_POINTS);
   localparam int  SW = $clog2(AW);
   localparam int  EW = DW + 2;
   localparam int  PW = 2 * DW + 1;
   localparam real PI = 3.14159265358979323846;

   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

   state_t state_q, state_d;

   logic [AW-1:0]   in_cnt;
   logic [AW-1:0]   out_cnt;
   logic [AW-2:0]   bf_cnt;
   logic [SW-1:0]   stage;
   logic            inv_q;
   logic            valid_q;
   logic            last_q;
   logic [2*DW-1:0] data_q;

   logic signed [DW-1:0] mem_re [FFT_POINTS];
   logic signed [DW-1:0] mem_im [FFT_POINTS];
   logic signed [DW-1:0] tw_cos [FFT_POINTS];
   logic signed [DW-1:0] tw_sin [FFT_POINTS];

   function automatic logic signed [DW-1:0] twiddle(input int k, input logic use_sin);
      real ang;
      real v;
      ang = 2.0 * PI * real'(k) / real'(FFT_POINTS);
      v   = (use_sin ? $sin(ang) : $cos(ang)) * real'(2 ** FRACTION);
      if (v >= 0.0) return DW'($rtoi(v + 0.5));
      else          return DW'(-$rtoi(0.5 - v));
   endfunction

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
      return r;
   endfunction

   function automatic logic signed [DW-1:0] sat(input logic signed [EW-1:0] v);
      logic signed [EW-1:0] hi;
      logic signed [EW-1:0] lo;
      hi = {3'b000, {(DW-1){1'b1}}};
      lo = {3'b111, {(DW-1){1'b0}}};
      if (v > hi)      return hi[DW-1:0];
      else if (v < lo) return lo[DW-1:0];
      else             return v[DW-1:0];
   endfunction

   // Upper half of the tables is never addressed; keeping N entries lets the
   // full-width twiddle index select without truncation.
   for (genvar k = 0; k < FFT_POINTS; k++) begin : g_tw
      assign tw_cos[k] = twiddle(k, 1'b0);
      assign tw_sin[k] = twiddle(k, 1'b1);
   end

   logic accept, load_last, comp_last, out_xfer, issue, unload_last;

   assign accept      = (state_q == ST_LOAD) && bus.fft_valid_in;
   assign load_last   = accept && (in_cnt == AW'(FFT_POINTS - 1));
   assign comp_last   = (state_q == ST_COMPUTE) && (&bf_cnt) && (stage == SW'(AW - 1));
   assign out_xfer    = valid_q && bus.fft_ready_out;
   assign issue       = (state_q == ST_UNLOAD) && !(valid_q && last_q) &&
                        (!valid_q || bus.fft_ready_out);
   assign unload_last = out_xfer && last_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:    if (load_last)   state_d = ST_COMPUTE;
         ST_COMPUTE: if (comp_last)   state_d = ST_UNLOAD;
         ST_UNLOAD:  if (unload_last) state_d = ST_LOAD;
         default:                     state_d = ST_LOAD;
      endcase
   end

   // Butterfly addressing: span = 2^stage, twiddle stride = N / 2^(stage+1).
   logic [AW-1:0] bf_ext, half, pos, a_idx, b_idx, tw_idx;
   logic [SW-1:0] tw_sh;

   always_comb begin
      bf_ext = {1'b0, bf_cnt};
      half   = AW'(1) << stage;
      pos    = bf_ext & (half - AW'(1));
      a_idx  = (((bf_ext >> stage) << 1) << stage) | pos;
      b_idx  = a_idx | half;
      tw_sh  = SW'(AW - 1) - stage;
      tw_idx = pos << tw_sh;
   end

   logic signed [DW-1:0] w_re, w_im;
   logic signed [PW-1:0] p_re, p_im;
   logic signed [EW-1:0] t_re, t_im, s_re, s_im, d_re, d_im;

   always_comb begin
      w_re = tw_cos[tw_idx];
      w_im = inv_q ? tw_sin[tw_idx] : -tw_sin[tw_idx];
      p_re = PW'(mem_re[b_idx]) * PW'(w_re) - PW'(mem_im[b_idx]) * PW'(w_im);
      p_im = PW'(mem_re[b_idx]) * PW'(w_im) + PW'(mem_im[b_idx]) * PW'(w_re);
      t_re = EW'(p_re >>> FRACTION);
      t_im = EW'(p_im >>> FRACTION);
      s_re = EW'(mem_re[a_idx]) + t_re;
      s_im = EW'(mem_im[a_idx]) + t_im;
      d_re = EW'(mem_re[a_idx]) - t_re;
      d_im = EW'(mem_im[a_idx]) - t_im;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_re[bitrev(in_cnt)] <= $signed(bus.fft_data_in[2*DW-1:DW]);
         mem_im[bitrev(in_cnt)] <= $signed(bus.fft_data_in[DW-1:0]);
      end else if (state_q == ST_COMPUTE) begin
         mem_re[a_idx] <= sat(s_re >>> 1);
         mem_im[a_idx] <= sat(s_im >>> 1);
         mem_re[b_idx] <= sat(d_re >>> 1);
         mem_im[b_idx] <= sat(d_im >>> 1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_LOAD;
         in_cnt  <= '0;
         out_cnt <= '0;
         bf_cnt  <= '0;
         stage   <= '0;
         inv_q   <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == '0) inv_q <= bus.fft_inverse;
         end
         if (state_q == ST_COMPUTE) begin
            bf_cnt <= bf_cnt + 1'b1;
            if (&bf_cnt) stage <= comp_last ? '0 : stage + 1'b1;
         end
         // Output register holds the current bin until it is taken downstream.
         if (issue) begin
            data_q  <= {mem_re[out_cnt], mem_im[out_cnt]};
            valid_q <= 1'b1;
            last_q  <= (out_cnt == AW'(FFT_POINTS - 1));
            out_cnt <= out_cnt + 1'b1;
         end else if (out_xfer) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
      end
   end

   assign bus.fft_ready_in  = (state_q == ST_LOAD);
   assign bus.fft_valid_out = valid_q;
   assign bus.fft_data_out  = data_q;
   assign bus.fft_last_out  = last_q;
endmodule

// File: tb/tb_fft_iter.sv
// Bench for fft_iter: random and directed frames compared against a direct
// floating-point DFT scaled by 1/N.
module tb_fft_iter;
   localparam int  DW  = 16;
   localparam int  FR  = 11;
   localparam int  N   = 8;
   localparam int  LAT = $clog2(N) * N / 2 + 1;
   localparam real PI  = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fft_iter_if #(.DATA_WIDTH(DW)) bus ();

   fft_iter #(.DATA_WIDTH(DW), .FRACTION(FR), .FFT_POINTS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_err = 0;
   int n_chk = 0;
   int x_re [N];
   int x_im [N];
   int ex_re [N];
   int ex_im [N];

   task automatic check(input string tag, input int obs, input int exp, input int tol);
      n_chk++;
      if (obs - exp > tol || exp - obs > tol) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic int rnd(input real v);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

   task automatic compute_ref(input bit inv);
      for (int k = 0; k < N; k++) begin
         real sr, si, th, c, s;
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < N; n++) begin
            th = 2.0 * PI * real'(k * n) / real'(N);
            c  = $cos(th);
            s  = $sin(th);
            if (!inv) begin
               sr += x_re[n] * c + x_im[n] * s;
               si += x_im[n] * c - x_re[n] * s;
            end else begin
               sr += x_re[n] * c - x_im[n] * s;
               si += x_im[n] * c + x_re[n] * s;
            end
         end
         ex_re[k] = rnd(sr / N);
         ex_im[k] = rnd(si / N);
      end
   endtask

   task automatic clear_x();
      for (int n = 0; n < N; n++) begin
         x_re[n] = 0;
         x_im[n] = 0;
      end
   endtask

   task automatic rand_x();
      for (int n = 0; n < N; n++) begin
         x_re[n] = int'($urandom_range(0, 4094)) - 2047;
         x_im[n] = int'($urandom_range(0, 4094)) - 2047;
      end
   endtask

   // Called at a negedge; returns just after the edge accepting sample N-1.
   task automatic load_frame(input bit inv, input bit gaps);
      int   n = 0;
      int   guard = 0;
      logic rdy;
      while (n < N) begin
         if (guard > 200) begin
            check("load_timeout", n, N, 0);
            break;
         end
         guard++;
         bus.fft_valid_in = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.fft_data_in  = {x_re[n][DW-1:0], x_im[n][DW-1:0]};
         bus.fft_inverse  = (n == 0) ? inv : 1'($urandom_range(0, 1));
         rdy = bus.fft_ready_in;
         @(posedge clk);
         if (bus.fft_valid_in && rdy) n++;
         if (n < N) @(negedge clk);
      end
   endtask

   // Starts just after the last-accept edge; ends at the negedge following bin N-1.
   task automatic drain_frame(input int tol, input int stall_bin, input int stall_len,
                              input bit hold_valid, input bit rand_ready);
      int   edges = 0;
      int   busy_rdy = 0;
      int   k = 0;
      int   stall = 0;
      int   guard = 0;
      bit   prev_stalled = 0;
      logic v, r;
      int   o_re, o_im;
      bus.fft_ready_out = 1'b1;
      forever begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (bus.fft_valid_out || edges > 100) break;
         if (bus.fft_ready_in) busy_rdy++;
         bus.fft_valid_in = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
         bus.fft_data_in  = $urandom;
      end
      check("latency", edges, LAT, 0);
      while (k < N && guard < 200) begin
         if (prev_stalled) check("hold_valid", int'(bus.fft_valid_out), 1, 0);
         if (bus.fft_valid_out) begin
            o_re = $signed(bus.fft_data_out[2*DW-1:DW]);
            o_im = $signed(bus.fft_data_out[DW-1:0]);
            check($sformatf("bin%0d_re", k), o_re, ex_re[k], tol);
            check($sformatf("bin%0d_im", k), o_im, ex_im[k], tol);
            check($sformatf("bin%0d_last", k), int'(bus.fft_last_out), int'(k == N - 1), 0);
         end
         if (k == stall_bin && stall < stall_len) begin
            r = 1'b0;
            stall++;
         end else begin
            r = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         bus.fft_ready_out = r;
         if (bus.fft_ready_in) busy_rdy++;
         bus.fft_valid_in = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
         bus.fft_data_in  = $urandom;
         v = bus.fft_valid_out;
         prev_stalled = v && !r;
         @(posedge clk);
         if (v && r) k++;
         @(negedge clk);
         guard++;
      end
      check("bins_delivered", k, N, 0);
      check("busy_ready_in", busy_rdy, 0, 0);
      check("ready_after_frame", int'(bus.fft_ready_in), 1, 0);
      check("valid_after_frame", int'(bus.fft_valid_out), 0, 0);
      bus.fft_valid_in = hold_valid;
   endtask

   initial begin
      bit inv;
      bus.fft_valid_in  = 1'b0;
      bus.fft_data_in   = '0;
      bus.fft_inverse   = 1'b0;
      bus.fft_ready_out = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready_in",  int'(bus.fft_ready_in),  1, 0);
      check("rst_valid_out", int'(bus.fft_valid_out), 0, 0);
      check("rst_last_out",  int'(bus.fft_last_out),  0, 0);
      check("rst_data_out",  int'(bus.fft_data_out),  0, 0);
      rst = 1'b1;

      // impulse, exact
      clear_x();
      x_re[0] = 2048;
      compute_ref(1'b0);
      load_frame(1'b0, 1'b0);
      drain_frame(0, -1, 0, 1'b0, 1'b0);

      // cosine at bin 1
      clear_x();
      x_re = '{2048, 1448, 0, -1448, -2048, -1448, 0, 1448};
      compute_ref(1'b0);
      load_frame(1'b0, 1'b1);
      drain_frame(2, -1, 0, 1'b0, 1'b0);

      // inverse of a single bin
      clear_x();
      x_re[1] = 2048;
      compute_ref(1'b1);
      load_frame(1'b1, 1'b0);
      drain_frame(1, -1, 0, 1'b0, 1'b0);

      // backpressure at bin 3 with stray valid pulses
      rand_x();
      compute_ref(1'b0);
      load_frame(1'b0, 1'b0);
      drain_frame(2, 3, 5, 1'b0, 1'b0);

      // reset during compute, then a clean impulse frame
      rand_x();
      load_frame(1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      bus.fft_valid_in = 1'b0;
      #1;
      check("midrst_ready_in",  int'(bus.fft_ready_in),  1, 0);
      check("midrst_valid_out", int'(bus.fft_valid_out), 0, 0);
      @(negedge clk);
      check("midrst_ready_in2",  int'(bus.fft_ready_in),  1, 0);
      check("midrst_valid_out2", int'(bus.fft_valid_out), 0, 0);
      check("midrst_data_out",   int'(bus.fft_data_out),  0, 0);
      @(negedge clk);
      rst = 1'b1;
      clear_x();
      x_re[0] = 2048;
      compute_ref(1'b0);
      load_frame(1'b0, 1'b0);
      drain_frame(0, -1, 0, 1'b0, 1'b0);

      // back-to-back with valid held high
      rand_x();
      compute_ref(1'b0);
      load_frame(1'b0, 1'b0);
      drain_frame(2, -1, 0, 1'b1, 1'b0);
      rand_x();
      compute_ref(1'b0);
      load_frame(1'b0, 1'b0);
      drain_frame(2, -1, 0, 1'b1, 1'b1);

      // random frames, random direction, random gaps and ready
      for (int f = 0; f < 4; f++) begin
         inv = 1'($urandom_range(0, 1));
         rand_x();
         compute_ref(inv);
         load_frame(inv, 1'b1);
         drain_frame(2, -1, 0, 1'b0, 1'b1);
      end

      bus.fft_valid_in = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fft_iter.md
FFT_ITER -- requirements
Module: fft_iter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement width of each real/imag component.
REQ-002 SHALL have parameter FRACTION, default 11, fractional bits of the fixed-point format (1.0 = 2^FRACTION); FRACTION <= DATA_WIDTH-2.
REQ-003 SHALL have parameter FFT_POINTS, default 8, transform length N; power of two, 4..1024.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 SHALL have port fft_ready_in  output  1  block can accept an input sample this cycle.
REQ-007 SHALL have port fft_valid_in  input  1  fft_data_in is valid.
REQ-008 SHALL have port fft_data_in  input  2*DATA_WIDTH  complex sample, {re, im}, re in upper half.
REQ-009 SHALL have port fft_inverse  input  1  1 = inverse transform; sampled on the first accepted sample of a frame.
REQ-010 SHALL have port fft_ready_out  input  1  downstream can accept an output sample.
REQ-011 SHALL have port fft_valid_out  output  1  fft_data_out is valid.
REQ-012 SHALL have port fft_data_out  output  2*DATA_WIDTH  complex result, {re, im}.
REQ-013 SHALL have port fft_last_out  output  1  high with fft_valid_out on bin N-1 only.

Function
REQ-014 SHALL implement an in-place iterative radix-2 DIT FFT using one butterfly and an N-entry complex register-array memory.
REQ-015 SHALL have states LOAD, COMPUTE, UNLOAD; LOAD->COMPUTE after the Nth accepted sample; COMPUTE->UNLOAD after log2(N)*N/2 cycles; UNLOAD->LOAD after the Nth output transfer.
REQ-016 LOAD: fft_ready_in=1; transfer on valid&ready; sample n written to address bitreverse(n, log2 N).
REQ-017 COMPUTE: one butterfly per cycle (read two, compute, write two same cycle), stages 0..log2(N)-1, N/2 butterflies per stage; fft_ready_in=0, fft_valid_out=0.
REQ-018 UNLOAD: fft_valid_out=1; fft_data_out = memory[k], natural order k=0..N-1; k advances only when fft_ready_out=1; data held stable while stalled.
REQ-019 Latency: first fft_valid_out SHALL assert exactly log2(N)*N/2+1 rising edges after the edge accepting the last input (13 for N=8).
REQ-020 fft_valid_in SHALL be ignored outside LOAD; no throughput overlap between frames.
REQ-021 Twiddles W^k = cos(2πk/N) - j·sin(2πk/N), k=0..N/2-1, SHALL be constant tables computed at elaboration, rounded to nearest at FRACTION bits; inverse mode uses +j·sin.
REQ-022 Butterfly: t = W·B with full-precision product then arithmetic shift right FRACTION; A' = (A+t)>>>1, B' = (A-t)>>>1 computed at DATA_WIDTH+2 bits, saturated to DATA_WIDTH.
REQ-023 Result SHALL therefore equal DFT/N (forward) or IDFT with 1/N (inverse), within ±2 LSB for non-saturating input.
REQ-024 fft_inverse latched at first accepted sample SHALL apply to the whole frame; later changes ignored until next frame.

Reset
REQ-025 While rst=0: state=LOAD, counters=0, fft_ready_in=1, fft_valid_out=0, fft_last_out=0, fft_data_out=0, inverse latch=0; memory contents need not be cleared.
REQ-026 Reset asserted in any state SHALL abort the frame immediately; first rising edge after release with fft_valid_in=1 accepts sample 0 of a new frame.

Verification (N=8, DATA_WIDTH=16, FRACTION=11, 1.0=0x0800)
REQ-027 Impulse: x0=0x0800, others 0, forward -> all 8 bins re=0x0100, im=0; fft_last_out only on bin 7.
REQ-028 Cosine: re = 0x0800,0x05A8,0,0xFA58,0xF800,0xFA58,0,0x05A8, im=0 -> bins 1 and 7 re=0x0400 ±2, all others 0 ±2; valid_out 13 edges after last input.
REQ-029 Inverse: X[1]=0x0800, others 0, fft_inverse=1 -> out[2] = (0, +0x0100), out[6] = (0, -0x0100), out[0] = (0x0100, 0), ±1 LSB.
REQ-030 Backpressure: fft_ready_out=0 for 5 cycles at bin 3 -> fft_data_out/fft_valid_out stable, all 8 bins delivered once in order; fft_valid_in pulses during COMPUTE/UNLOAD ignored.
REQ-031 Reset mid-COMPUTE: rst=0 for 2 cycles -> fft_valid_out=0, fft_ready_in=1 during reset; following impulse frame yields REQ-027 result.
REQ-032 Back-to-back: two frames with fft_valid_in held 1 -> second frame accepted only after first frame's bin 7 transfer, both results correct.
